des_key_schedule_ctrl: RTL and testbench

Sequential DES key-schedule controller that sequences one 48-bit round subkey per accepted handshake to the iterative DES round datapath.
- Accepts a 64-bit key plus an encrypt/decrypt mode through a valid/ready start handshake.
- Holds the 56-bit C/D state after PC-1 and rotates it per the DES shift schedule: left for encrypt, right for decrypt (reverse subkey order).
- Emits PC-2 of the current state for rounds 1..16, then pulses done.
- Replaces the all-16-at-once combinational subkey generator for area-constrained iterative cores.

---
 rtl/des_pkg.sv | 55 +++++
 rtl/des_pc2.sv | 17 +
 rtl/des_key_schedule_ctrl.sv | 115 +++++++++++
 tb/tb_des_key_schedule_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// DES key-schedule tables, FSM state encodings and the C/D rotation helper
// shared by the iterative subkey controller and the PC-2 permutation.
package des_pkg;

   localparam int unsigned DES_ROUNDS = 16;
   localparam int unsigned CD_W       = 56;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int unsigned PC1_TABLE [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int unsigned PC2_TABLE [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   localparam int unsigned SHIFT_SCHEDULE [16] = '{
      1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
   };

   // Rotate C and D halves independently by one or two positions.
   function automatic logic [1:56] rot_cd(input logic [1:56] v, input logic right,
                                          input logic two);
      logic [1:28] c;
      logic [1:28] d;
      c = v[1:28];
      d = v[29:56];
      if (!right) begin
         c = two ? {c[3:28], c[1:2]} : {c[2:28], c[1]};
         d = two ? {d[3:28], d[1:2]} : {d[2:28], d[1]};
      end else begin
         c = two ? {c[27:28], c[1:26]} : {c[28], c[1:27]};
         d = two ? {d[27:28], d[1:26]} : {d[28], d[1:27]};
      end
      return {c, d};
   endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2: selects the 48 subkey bits from the 56-bit C/D state.
module des_pc2
   import des_pkg::*;
(
   input  logic [1:56] cd,
   output logic [1:48] subkey
);

   for (genvar g = 0; g < 48; g++) begin : g_bit
      assign subkey[g+1] = cd[PC2_TABLE[g]];
   end

   // Bits PC-2 discards by construction.
   logic unused_drop;
   assign unused_drop = ^{cd[9], cd[18], cd[22], cd[25], cd[35], cd[38], cd[43], cd[54]};

endmodule

// File: rtl/des_key_schedule_ctrl.sv
// Iterative DES key schedule: one PC-2 subkey per handshake, forward order for
// encrypt, reverse order for decrypt, followed by a one-cycle done pulse.
module des_key_schedule_ctrl
   import des_pkg::*;
#(
   parameter int unsigned KEY_W    = 64,
   parameter int unsigned SUBKEY_W = 48,
   parameter int unsigned ROUNDS   = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start_valid,
   output logic                start_ready,
   input  logic [1:KEY_W]      key,
   input  logic                decrypt,
   output logic                subkey_valid,
   input  logic                subkey_ready,
   output logic [1:SUBKEY_W]   subkey,
   output logic [3:0]          round_idx,
   input  logic                abort,
   output logic                done
);

   localparam int unsigned RND_W = $clog2(ROUNDS);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [1:CD_W]    cd;
   logic [1:CD_W]    cd_nxt;
   logic [1:CD_W]    pc1_key;
   logic [RND_W-1:0] round_nxt;
   logic             mode;
   logic             mode_nxt;
   logic             hs;
   logic             two_enc;
   logic             two_dec;

   for (genvar g = 0; g < 56; g++) begin : g_pc1
      assign pc1_key[g+1] = key[PC1_TABLE[g]];
   end

   logic unused_parity;
   assign unused_parity = ^{key[8], key[16], key[24], key[32], key[40], key[48], key[56], key[64]};

   des_pc2 u_pc2 (
      .cd     (cd),
      .subkey (subkey)
   );

   assign hs      = subkey_valid && subkey_ready;
   // Encrypt moves to C(r+2); decrypt walks back from C(16-r) to C(15-r).
   assign two_enc = (SHIFT_SCHEDULE[round_idx + RND_W'(1)] == 2);
   assign two_dec = (SHIFT_SCHEDULE[RND_W'(ROUNDS - 1) - round_idx] == 2);

   // Next-state, datapath and output decode.
   always_comb begin
      state_nxt = state;
      cd_nxt    = cd;
      round_nxt = round_idx;
      mode_nxt  = mode;
      case (state)
         ST_IDLE: begin
            if (start_valid) begin
               mode_nxt  = decrypt;
               cd_nxt    = decrypt ? pc1_key : rot_cd(pc1_key, 1'b0, 1'b0);
               round_nxt = '0;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_nxt = ST_IDLE;
               round_nxt = '0;
            end else if (hs) begin
               if (round_idx == RND_W'(ROUNDS - 1)) begin
                  state_nxt = ST_DONE;
                  round_nxt = '0;
               end else begin
                  round_nxt = round_idx + RND_W'(1);
                  cd_nxt    = mode ? rot_cd(cd, 1'b1, two_dec) : rot_cd(cd, 1'b0, two_enc);
               end
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
            round_nxt = '0;
         end
         default: begin
            state_nxt = ST_IDLE;
            round_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         cd           <= '0;
         round_idx    <= '0;
         mode         <= 1'b0;
         start_ready  <= 1'b1;
         subkey_valid <= 1'b0;
         done         <= 1'b0;
      end else begin
         state        <= state_nxt;
         cd           <= cd_nxt;
         round_idx    <= round_nxt;
         mode         <= mode_nxt;
         start_ready  <= (state_nxt == ST_IDLE);
         subkey_valid <= (state_nxt == ST_RUN);
         done         <= (state_nxt == ST_DONE);
      end
   end

endmodule

// File: tb/tb_des_key_schedule_ctrl.sv
// Directed bench for des_key_schedule_ctrl using the classic 0x133457799BBCDFF1 key.
module tb_des_key_schedule_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start_valid;
   logic        start_ready;
   logic [63:0] key;
   logic        decrypt;
   logic        subkey_valid;
   logic        subkey_ready;
   logic [47:0] subkey;
   logic [3:0]  round_idx;
   logic        abort;
   logic        done;

   int checks = 0;
   int errors = 0;

   logic [47:0] exp_k [16];
   localparam logic [63:0] TKEY = 64'h1334_5779_9BBC_DFF1;

   des_key_schedule_ctrl dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start_valid  (start_valid),
      .start_ready  (start_ready),
      .key          (key),
      .decrypt      (decrypt),
      .subkey_valid (subkey_valid),
      .subkey_ready (subkey_ready),
      .subkey       (subkey),
      .round_idx    (round_idx),
      .abort        (abort),
      .done         (done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int hs;
      int cyc;
      int last;
      int accepts;
      logic rdy;

      exp_k = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
                48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
                48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
                48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

      // Reset with start_valid asserted: must be ignored.
      reset_n = 1'b0; start_valid = 1'b1; key = TKEY; decrypt = 1'b0;
      subkey_ready = 1'b1; abort = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_start_ready", 64'(start_ready), 64'd1);
      chk("rst_valid", 64'(subkey_valid), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_round", 64'(round_idx), 64'd0);
      chk("rst_subkey", 64'(subkey), 64'd0);
      reset_n = 1'b1; start_valid = 1'b0;
      @(negedge clk);
      chk("idle_start_ready", 64'(start_ready), 64'd1);
      chk("idle_valid", 64'(subkey_valid), 64'd0);

      // Encrypt, full throughput; key changed after accept must not matter.
      start_valid = 1'b1; key = TKEY; decrypt = 1'b0;
      @(negedge clk);
      start_valid = 1'b0; key = 64'hFFFF_FFFF_FFFF_FFFF; decrypt = 1'b1;
      chk("enc_start_ready_low", 64'(start_ready), 64'd0);
      for (int r = 0; r < 16; r++) begin
         chk("enc_valid", 64'(subkey_valid), 64'd1);
         chk("enc_round", 64'(round_idx), 64'(r));
         chk("enc_subkey", 64'(subkey), 64'(exp_k[r]));
         chk("enc_no_done", 64'(done), 64'd0);
         @(negedge clk);
      end
      chk("enc_done", 64'(done), 64'd1);
      chk("enc_done_valid", 64'(subkey_valid), 64'd0);
      chk("enc_done_ready", 64'(start_ready), 64'd0);
      @(negedge clk);
      chk("enc_done_pulse", 64'(done), 64'd0);
      chk("enc_back_idle", 64'(start_ready), 64'd1);

      // Decrypt: reverse order.
      start_valid = 1'b1; key = TKEY; decrypt = 1'b1;
      @(negedge clk);
      start_valid = 1'b0; key = 64'h0; decrypt = 1'b0;
      for (int r = 0; r < 16; r++) begin
         chk("dec_valid", 64'(subkey_valid), 64'd1);
         chk("dec_round", 64'(round_idx), 64'(r));
         chk("dec_subkey", 64'(subkey), 64'(exp_k[15-r]));
         @(negedge clk);
      end
      chk("dec_done", 64'(done), 64'd1);
      @(negedge clk);

      // Backpressure with pseudo-random ready.
      start_valid = 1'b1; key = TKEY; decrypt = 1'b0;
      @(negedge clk);
      start_valid = 1'b0;
      hs = 0; cyc = 0;
      while (hs < 16 && cyc < 300) begin
         chk("bp_valid", 64'(subkey_valid), 64'd1);
         chk("bp_round", 64'(round_idx), 64'(hs));
         chk("bp_subkey", 64'(subkey), 64'(exp_k[hs]));
         chk("bp_no_done", 64'(done), 64'd0);
         rdy = 1'($urandom_range(0, 1));
         subkey_ready = rdy;
         @(negedge clk);
         cyc++;
         if (rdy) hs++;
      end
      chk("bp_handshakes", 64'(hs), 64'd16);
      chk("bp_done", 64'(done), 64'd1);
      subkey_ready = 1'b1;
      @(negedge clk);

      // Abort at round 7 (with a simultaneous handshake), then all-zero key.
      start_valid = 1'b1; key = TKEY; decrypt = 1'b0;
      @(negedge clk);
      start_valid = 1'b0;
      repeat (7) @(negedge clk);
      chk("abort_round", 64'(round_idx), 64'd7);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_valid", 64'(subkey_valid), 64'd0);
      chk("abort_ready", 64'(start_ready), 64'd1);
      chk("abort_no_done", 64'(done), 64'd0);
      start_valid = 1'b1; key = 64'h0; decrypt = 1'b0;
      @(negedge clk);
      start_valid = 1'b0;
      for (int r = 0; r < 16; r++) begin
         chk("zero_round", 64'(round_idx), 64'(r));
         chk("zero_subkey", 64'(subkey), 64'd0);
         chk("zero_valid", 64'(subkey_valid), 64'd1);
         @(negedge clk);
      end
      chk("zero_done", 64'(done), 64'd1);
      @(negedge clk);

      // Reset mid-run at round 5.
      start_valid = 1'b1; key = TKEY; decrypt = 1'b0;
      @(negedge clk);
      start_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("mid_round", 64'(round_idx), 64'd5);
      reset_n = 1'b0; start_valid = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready", 64'(start_ready), 64'd1);
      chk("mid_rst_valid", 64'(subkey_valid), 64'd0);
      chk("mid_rst_round", 64'(round_idx), 64'd0);
      chk("mid_rst_subkey", 64'(subkey), 64'd0);
      chk("mid_rst_done", 64'(done), 64'd0);
      @(negedge clk);
      chk("mid_rst_hold_valid", 64'(subkey_valid), 64'd0);
      reset_n = 1'b1; start_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_idle", 64'(start_ready), 64'd1);
      chk("post_rst_valid", 64'(subkey_valid), 64'd0);

      // start_valid held high: back-to-back accepts every 18 cycles.
      start_valid = 1'b1; key = TKEY; decrypt = 1'b0; subkey_ready = 1'b1;
      last = -1; accepts = 0;
      for (cyc = 0; cyc < 60; cyc++) begin
         if (subkey_valid || done)
            chk("stream_ready_low", 64'(start_ready), 64'd0);
         if (last >= 0 && cyc == last + 1)
            chk("stream_first_subkey", 64'(subkey), 64'(exp_k[0]));
         if (start_ready) begin
            if (last >= 0)
               chk("stream_gap", 64'(cyc - last), 64'd18);
            last = cyc;
            accepts++;
         end
         @(negedge clk);
      end
      chk("stream_accepts", 64'(accepts), 64'd4);
      start_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
